// File: rtl/alu_result_queue.sv
// alu_result_queue: collects the four ALU unit results, keeps only the
// highest-priority valid one per cycle, tags it with its source unit and
// buffers it in a show-ahead FIFO read through a valid/ready handshake.
// Dropped pushes and multi-flag cycles are reported via sticky error bits.
module alu_result_queue #(
   parameter int width = 8,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [2*width-1:0]         Arith_Out,
   input  logic                       Arith_Flag,
   input  logic [width-1:0]           Logic_Out,
   input  logic                       Logic_Flag,
   input  logic [width-1:0]           CMP_Out,
   input  logic                       CMP_Flag,
   input  logic [width-1:0]           SHIFT_Out,
   input  logic                       SHIFT_Flag,
   input  logic                       Res_Ready,
   input  logic                       Clr_Err,
   output logic                       Res_Valid,
   output logic [2*width-1:0]         Res_Data,
   output logic [1:0]                 Res_Src,
   output logic [$clog2(DEPTH):0]     Fill,
   output logic                       Overflow,
   output logic                       Multi_Err
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;
   localparam int RES_W  = 2 * width;
   localparam int ENT_W  = RES_W + 2;

   localparam logic [1:0] SRC_ARITH = 2'b00;
   localparam logic [1:0] SRC_LOGIC = 2'b01;
   localparam logic [1:0] SRC_CMP   = 2'b10;
   localparam logic [1:0] SRC_SHIFT = 2'b11;

   // Entry storage; contents are never reset, only the pointers are.
   logic [ENT_W-1:0]  mem_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0] fill_q,   fill_d;
   logic              ovf_q,    ovf_d;
   logic              multi_q,  multi_d;

   logic [3:0]        flags;
   logic              push_req;
   logic              multi_hit;
   logic [1:0]        win_src;
   logic [RES_W-1:0]  win_data;
   logic              not_empty;
   logic              full;
   logic              pop;
   logic              drop;
   logic              do_push;
   logic [ENT_W-1:0]  head;

   assign flags     = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
   assign push_req  = |flags;
   // More than one bit set: clearing the lowest set bit leaves something.
   assign multi_hit = (flags & (flags - 4'd1)) != 4'd0;

   // Pick the winning unit (Arith > Logic > CMP > Shift) and zero-extend it.
   always_comb begin
      win_src  = SRC_ARITH;
      win_data = '0;
      if (Arith_Flag) begin
         win_src  = SRC_ARITH;
         win_data = Arith_Out;
      end else if (Logic_Flag) begin
         win_src  = SRC_LOGIC;
         win_data = {{width{1'b0}}, Logic_Out};
      end else if (CMP_Flag) begin
         win_src  = SRC_CMP;
         win_data = {{width{1'b0}}, CMP_Out};
      end else if (SHIFT_Flag) begin
         win_src  = SRC_SHIFT;
         win_data = {{width{1'b0}}, SHIFT_Out};
      end
   end

   // Handshake decode: pops only when something is queued; a push into a
   // full FIFO survives only if the head leaves in the same cycle.
   always_comb begin
      not_empty = (fill_q != '0);
      full      = (fill_q == FILL_W'(DEPTH));
      pop       = not_empty && Res_Ready;
      drop      = push_req && full && !pop;
      do_push   = push_req && !drop;
   end

   // Next-state for pointers, fill counter and sticky error bits.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      ovf_d    = ovf_q;
      multi_d  = multi_q;

      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({do_push, pop})
         2'b10:   fill_d = fill_q + FILL_W'(1);
         2'b01:   fill_d = fill_q - FILL_W'(1);
         default: fill_d = fill_q;
      endcase

      // Clear first so that a set in the same cycle takes precedence.
      if (Clr_Err) begin
         ovf_d   = 1'b0;
         multi_d = 1'b0;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end
      if (multi_hit) begin
         multi_d = 1'b1;
      end
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         ovf_q    <= 1'b0;
         multi_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         ovf_q    <= ovf_d;
         multi_q  <= multi_d;
      end
   end

   // Entry write; a dropped push leaves the storage untouched.
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= {win_src, win_data};
      end
   end

   // Show-ahead head presentation, forced to zero while empty.
   assign head      = mem_q[rd_ptr_q];
   assign Res_Valid = not_empty;
   assign Res_Data  = not_empty ? head[RES_W-1:0]     : '0;
   assign Res_Src   = not_empty ? head[ENT_W-1:RES_W] : 2'b00;
   assign Fill      = fill_q;
   assign Overflow  = ovf_q;
   assign Multi_Err = multi_q;

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Downstream stage of the 8-bit ALU top level. It consumes the four unit result/flag pairs (arithmetic, logic, compare, shift), tags each valid result with its source unit, and buffers it in a small show-ahead FIFO. It presents the results to the consumer through a valid/ready handshake. Overflow and multi-flag conditions are reported through sticky error bits.

## Interface
- `width`, 8: operand width of the upstream ALU; the result word is `2*width` bits.
- `DEPTH`, 4: FIFO depth in entries; must be a power of 2 and at least 2.

Ports:
- `CLK`  in  1  single clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `Arith_Out`  in  2*width  arithmetic unit result.
- `Arith_Flag`  in  1  arithmetic result valid this cycle.
- `Logic_Out`  in  width  logic unit result.
- `Logic_Flag`  in  1  logic result valid this cycle.
- `CMP_Out`  in  width  compare unit result.
- `CMP_Flag`  in  1  compare result valid this cycle.
- `SHIFT_Out`  in  width  shift unit result.
- `SHIFT_Flag`  in  1  shift result valid this cycle.
- `Res_Ready`  in  1  consumer accepts the head entry this cycle.
- `Clr_Err`  in  1  synchronous clear of both sticky error bits.
- `Res_Valid`  out  1  FIFO non-empty.
- `Res_Data`  out  2*width  head entry result; width-bit sources are zero-extended.
- `Res_Src`  out  2  head entry source: 00 arith, 01 logic, 10 cmp, 11 shift.
- `Fill`  out  log2(DEPTH)+1  current entry count.
- `Overflow`  out  1  sticky: at least one result was dropped because the FIFO was full.
- `Multi_Err`  out  1  sticky: more than one flag was high in the same cycle.

## Operation
- **Push condition.** A push is requested in any cycle where one or more `*_Flag` inputs are high.
- **Priority.** When several flags are high, priority is Arith > Logic > CMP > Shift.
  - Only the winning unit's result is enqueued.
  - `Multi_Err` is set.
- **Entry format.** Each entry is `{Res_Src, zero-extended result}`, i.e. `2*width+2` bits.
- **Pop condition.** A pop occurs when `Res_Valid && Res_Ready`. When `Res_Valid` is low, `Res_Ready` is ignored.
- **Show-ahead output.**
  - `Res_Data` and `Res_Src` always reflect the head entry.
  - Both are forced to 0 when the FIFO is empty.
- **Pointers and fill.**
  - Read and write pointers wrap modulo `DEPTH`.
  - `Fill` is an up/down counter: +1 on push only, −1 on pop only, unchanged on both or neither.
- **Full FIFO.**
  - Push without pop in the same cycle: the new result is dropped, `Overflow` is set, and no state other than `Overflow` changes.
  - Push and pop in the same cycle: both are performed and no drop occurs.
- **Empty FIFO.**
  - There is no bypass. A push sets `Res_Valid` on the following cycle.
  - A `Res_Ready` asserted in that same cycle has no effect.
- **Error clearing.**
  - `Clr_Err` clears `Overflow` and `Multi_Err`.
  - If a set event occurs in the same cycle, the set wins.
- **Reset.** `RST` low asynchronously returns the block to its reset state:
  - Pointers and `Fill` are 0.
  - `Res_Valid`, `Res_Data`, `Res_Src`, `Overflow` and `Multi_Err` are 0.
  - Queued entries are discarded; memory contents need not be cleared.
  - A reset asserted in the middle of a burst simply empties the queue.

## Timing
- **Enqueue latency.** A flag sampled high at rising edge n appears at the head at edge n when the FIFO was empty. `Res_Valid` is therefore high during cycle n+1.
- **Dequeue.** A pop at edge n advances the head. The next entry, or the empty indication, is visible after edge n.
- **Throughput.** Sustained rate is one push and one pop per cycle, with no bubbles.
- **Handshake stability.** While `Res_Valid` is high and `Res_Ready` is low, `Res_Data` and `Res_Src` hold steady.
- **Combinational paths.** All outputs are driven from registers plus head-entry muxing. There is no combinational path from `*_Flag` or `Res_Ready` to any output.
- **Sticky errors.** `Overflow` and `Multi_Err` update at the edge on which the triggering push is sampled.

## Test plan
1. **Single push and pop.** Reset, then `Logic_Flag`=1 with `Logic_Out`=0xA5 for one cycle, `Res_Ready`=0.
   - Next cycle: `Res_Valid`=1, `Res_Data`=0x00A5, `Res_Src`=01, `Fill`=1.
   - Raise `Res_Ready` for one cycle: `Res_Valid`=0, `Res_Data`=0, `Fill`=0.
2. **Ordering.** Consecutive single-flag cycles: Arith 0x1234, CMP 0x01, Shift 0x80, with `Res_Ready`=0.
   - `Fill`=3.
   - Draining yields (00,0x1234), (10,0x0001), (11,0x0080) in that order.
3. **Overflow.** Five pushes with `Res_Ready`=0 and `DEPTH`=4, values 1..5.
   - `Fill`=4 and `Overflow`=1.
   - Draining returns 1..4; value 5 is absent.
   - `Clr_Err` then returns `Overflow` to 0.
4. **Full with simultaneous push and pop.** On a full FIFO, push 0x77 with `Res_Ready`=1.
   - The head advances, `Fill` stays 4, `Overflow` stays 0.
   - 0x77 is drained last.
5. **Multi-flag.** `Arith_Flag` and `SHIFT_Flag` high together, `Arith_Out`=0x0102, `SHIFT_Out`=0x04.
   - Exactly one entry (00,0x0102) is enqueued.
   - `Multi_Err`=1.
6. **Reset mid-operation.** Pull `RST` low asynchronously between edges while `Fill`=3 and `Overflow`=1.
   - All outputs go to 0 immediately.
   - After release, one push behaves exactly as in scenario 1.
